// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_ctrl_pkg;

   // Fetch sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   // Size of one instruction word in bytes; the sequential PC step.
   localparam logic [31:0] INSTR_BYTES        = 32'd4;

   // First fetch address after reset unless overridden.
   localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

   // Clear the byte-offset bits so every fetch address is word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request port and decode hand-off port of the fetch controller.
//
// Handshake rules:
//  - imem: a request is transferred in the cycle where imem_req_o and imem_gnt_i
//    are both high; imem_req_o and imem_addr_o stay stable until that cycle.
//    The single outstanding response arrives later as a one-cycle imem_rvalid_i.
//  - decode: an instruction is transferred in the cycle where instr_valid_o and
//    instr_ready_i are both high; instr_o/instr_pc_o stay stable while
//    instr_valid_o is high and instr_ready_i is low.
interface fetch_ctrl_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;

   // Fetch controller side.
   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i,
      output instr_valid_o,
      output instr_o,
      output instr_pc_o,
      input  instr_ready_i
   );

   // Memory / decode side.
   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i,
      input  instr_valid_o,
      input  instr_o,
      input  instr_pc_o,
      output instr_ready_i
   );
endinterface

// File: rtl/fetch_ctrl_pc_reg.sv
// Program counter register: redirect load has priority over the +4 step.
module fetch_ctrl_pc_reg
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] load_addr_i,
   input  logic        inc_i,
   output logic [31:0] pc_o
);

   logic [31:0] r_pc;

   // PC update: load target, otherwise step by one word (wraps modulo 2^32).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pc <= RESET_ADDR;
      end else if (load_i) begin
         r_pc <= load_addr_i;
      end else if (inc_i) begin
         r_pc <= r_pc + INSTR_BYTES;
      end
   end

   assign pc_o = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, redirect/stall
// handling and a single-entry buffer towards decode.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         stall_i,
   input  logic         redirect_i,
   input  logic [31:0]  redirect_addr_i,
   fetch_ctrl_if.master bus,
   output fetch_state_e dbg_state_o
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   fetch_state_e w_resume_state;
   logic         r_kill;
   logic         w_kill_nxt;
   logic         w_load_buf;
   logic         w_pc_inc;
   logic [31:0]  r_instr;
   logic [31:0]  r_instr_pc;
   logic [31:0]  w_pc;
   logic [31:0]  w_redirect_tgt;

   assign w_redirect_tgt = word_align(redirect_addr_i);

   // After a completed or abandoned transfer, a new request only starts when not stalled.
   assign w_resume_state = stall_i ? IDLE : REQ;

   fetch_ctrl_pc_reg #(
      .RESET_ADDR (RESET_ADDR)
   ) u_pc_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (redirect_i),
      .load_addr_i (w_redirect_tgt),
      .inc_i       (w_pc_inc),
      .pc_o        (w_pc)
   );

   // State, kill flag and decode buffer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_kill     <= 1'b0;
         r_instr    <= 32'h0;
         r_instr_pc <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_kill  <= w_kill_nxt;
         if (w_load_buf) begin
            r_instr    <= bus.imem_rdata_i;
            r_instr_pc <= w_pc;
         end
      end
   end

   // Next-state decode; a redirect reloads the PC in every state via the pc_reg load port.
   always_comb begin
      w_state_nxt = r_state;
      w_kill_nxt  = r_kill;
      w_load_buf  = 1'b0;
      w_pc_inc    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!stall_i) begin
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            // Without a grant the new PC simply becomes the pending address.
            if (bus.imem_gnt_i) begin
               w_state_nxt = WAIT;
               w_kill_nxt  = redirect_i;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid_i) begin
               if (r_kill || redirect_i) begin
                  // Response belongs to an abandoned path: drop it.
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = w_resume_state;
               end else begin
                  w_load_buf  = 1'b1;
                  w_pc_inc    = 1'b1;
                  w_state_nxt = HOLD;
               end
            end else if (redirect_i) begin
               w_kill_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_i || bus.instr_ready_i) begin
               w_state_nxt = w_resume_state;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_kill_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.imem_req_o    = (r_state == REQ);
   assign bus.imem_addr_o   = w_pc;
   assign bus.instr_valid_o = (r_state == HOLD);
   assign bus.instr_o       = r_instr;
   assign bus.instr_pc_o    = r_instr_pc;
   assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: main instance at reset address 0 with a small
// memory responder, plus a second instance at 0xFFFF_FFFC for PC wrap-around.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_addr = 32'h0;
  logic         ready = 1'b0;
  fetch_state_e dut_state;

  fetch_ctrl_if u_bus ();

  fetch_ctrl #(.RESET_ADDR(32'h0000_0000)) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .bus             (u_bus),
    .dbg_state_o     (dut_state)
  );

  // ---------------- wrap-around DUT ----------------
  logic         hi_gnt = 1'b0;
  logic         hi_rvalid = 1'b0;
  logic [31:0]  hi_rdata = 32'h0;
  logic         hi_ready = 1'b0;
  fetch_state_e hi_state;

  fetch_ctrl_if u_hi_bus ();

  assign u_hi_bus.imem_gnt_i    = hi_gnt;
  assign u_hi_bus.imem_rvalid_i = hi_rvalid;
  assign u_hi_bus.imem_rdata_i  = hi_rdata;
  assign u_hi_bus.instr_ready_i = hi_ready;

  fetch_ctrl #(.RESET_ADDR(32'hFFFF_FFFC)) u_dut_hi (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (1'b0),
    .redirect_i      (1'b0),
    .redirect_addr_i (32'h0),
    .bus             (u_hi_bus),
    .dbg_state_o     (hi_state)
  );

  // ---------------- memory responder ----------------
  // mem_auto=1: grant when requested (optionally delayed at one address),
  // return rdata = request address after cfg_rv_delay extra cycles.
  logic        mem_auto = 1'b0;
  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        a_gnt = 1'b0;
  logic        a_rvalid = 1'b0;
  logic [31:0] a_rdata = 32'h0;
  logic [31:0] cfg_gnt_addr = 32'hFFFF_FFFF;
  int          cfg_gnt_delay = 0;
  int          cfg_rv_delay = 0;
  int          gnt_left = 0;
  int          rv_left = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  assign u_bus.imem_gnt_i    = mem_auto ? a_gnt    : m_gnt;
  assign u_bus.imem_rvalid_i = mem_auto ? a_rvalid : m_rvalid;
  assign u_bus.imem_rdata_i  = mem_auto ? a_rdata  : m_rdata;
  assign u_bus.instr_ready_i = ready;

  always @(negedge clk) begin
    if (!mem_auto) begin
      pend     = 1'b0;
      a_gnt    = 1'b0;
      a_rvalid = 1'b0;
      gnt_left = cfg_gnt_delay;
    end else begin
      if (pend) begin
        if (rv_left > 0) begin
          rv_left  = rv_left - 1;
          a_rvalid = 1'b0;
        end else begin
          a_rvalid = 1'b1;
          a_rdata  = pend_addr;
          pend     = 1'b0;
        end
      end else begin
        a_rvalid = 1'b0;
      end
      if (u_bus.imem_req_o) begin
        if (u_bus.imem_addr_o == cfg_gnt_addr && gnt_left > 0) begin
          gnt_left = gnt_left - 1;
          a_gnt    = 1'b0;
        end else begin
          a_gnt     = 1'b1;
          pend      = 1'b1;
          pend_addr = u_bus.imem_addr_o;
          rv_left   = cfg_rv_delay;
        end
      end else begin
        a_gnt = 1'b0;
      end
    end
  end

  // ---------------- monitor (mid-cycle) ----------------
  logic [31:0] grant_q[$];
  logic [31:0] hs_pc_q[$];
  logic [31:0] hs_instr_q[$];
  int          hs_cyc_q[$];
  int          req8_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      grant_q.delete();
      hs_pc_q.delete();
      hs_instr_q.delete();
      hs_cyc_q.delete();
      req8_cnt = 0;
    end else begin
      if (u_bus.imem_req_o && u_bus.imem_gnt_i) grant_q.push_back(u_bus.imem_addr_o);
      if (u_bus.instr_valid_o && ready) begin
        hs_pc_q.push_back(u_bus.instr_pc_o);
        hs_instr_q.push_back(u_bus.instr_o);
        hs_cyc_q.push_back(cyc);
      end
      if (u_bus.imem_req_o && u_bus.imem_addr_o == 32'h8) req8_cnt = req8_cnt + 1;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] gnt_addr, input int gnt_delay, input int rv_delay);
    rst           = 1'b1;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'h0;
    ready         = 1'b0;
    mem_auto      = 1'b0;
    m_gnt         = 1'b0;
    m_rvalid      = 1'b0;
    m_rdata       = 32'h0;
    cfg_gnt_addr  = gnt_addr;
    cfg_gnt_delay = gnt_delay;
    cfg_rv_delay  = rv_delay;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (u_bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", u_bus.imem_req_o); end
    n_cmp++; if (u_bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 00000000", u_bus.imem_addr_o); end
    n_cmp++; if (u_bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", u_bus.instr_valid_o); end
    n_cmp++; if (u_bus.instr_o !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 00000000", u_bus.instr_o); end
    n_cmp++; if (u_bus.instr_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 00000000", u_bus.instr_pc_o); end
    n_cmp++; if (dut_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dut_state, IDLE); end
    n_cmp++; if (u_hi_bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL reset_addr_hi: got %h want fffffffc", u_hi_bus.imem_addr_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (u_bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL req_at_release: got %b want 0", u_bus.imem_req_o); end
    step();
    n_cmp++; if (u_bus.imem_req_o !== 1'b1) begin n_err++; $display("FAIL req_one_after_release: got %b want 1", u_bus.imem_req_o); end
    n_cmp++; if (u_bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 00000000", u_bus.imem_addr_o); end
  endtask

  task automatic test_wrap();
    n_cmp++; if (u_hi_bus.imem_req_o !== 1'b1 || u_hi_bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first_req: got req=%b addr=%h want req=1 addr=fffffffc", u_hi_bus.imem_req_o, u_hi_bus.imem_addr_o); end
    hi_gnt = 1'b1;
    step();
    hi_gnt = 1'b0;
    n_cmp++; if (hi_state !== WAIT) begin n_err++; $display("FAIL wrap_wait_state: got %0d want %0d", hi_state, WAIT); end
    hi_rvalid = 1'b1;
    hi_rdata  = 32'h1234_5678;
    step();
    hi_rvalid = 1'b0;
    n_cmp++; if (u_hi_bus.instr_valid_o !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b want 1", u_hi_bus.instr_valid_o); end
    n_cmp++; if (u_hi_bus.instr_o !== 32'h1234_5678) begin n_err++; $display("FAIL wrap_instr: got %h want 12345678", u_hi_bus.instr_o); end
    n_cmp++; if (u_hi_bus.instr_pc_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_instr_pc: got %h want fffffffc", u_hi_bus.instr_pc_o); end
    hi_ready = 1'b1;
    step();
    hi_ready = 1'b0;
    n_cmp++; if (u_hi_bus.imem_req_o !== 1'b1 || u_hi_bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL wrap_second_addr: got req=%b addr=%h want req=1 addr=00000000", u_hi_bus.imem_req_o, u_hi_bus.imem_addr_o); end
    n_cmp++; if (u_hi_bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL wrap_valid_drop: got %b want 0", u_hi_bus.instr_valid_o); end
  endtask

  task automatic test_sequential();
    do_reset(32'hFFFF_FFFF, 0, 0);
    mem_auto = 1'b1;
    ready    = 1'b1;
    for (int i = 0; i < 40 && hs_pc_q.size() < 4; i++) step();
    n_cmp++; if (hs_pc_q.size() < 4) begin n_err++; $display("FAIL seq_timeout: got %0d handshakes want 4", hs_pc_q.size()); end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (grant_q[i] !== exp_q[i]) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", i, grant_q[i], exp_q[i]); end
      n_cmp++; if (hs_pc_q[i] !== exp_q[i]) begin n_err++; $display("FAIL seq_instr_pc[%0d]: got %h want %h", i, hs_pc_q[i], exp_q[i]); end
      n_cmp++; if (hs_instr_q[i] !== exp_q[i]) begin n_err++; $display("FAIL seq_instr[%0d]: got %h want %h", i, hs_instr_q[i], exp_q[i]); end
    end
    n_cmp++; if (hs_cyc_q[1] - hs_cyc_q[0] !== 3) begin n_err++; $display("FAIL seq_rate: got %0d cycles want 3", hs_cyc_q[1] - hs_cyc_q[0]); end
    n_cmp++; if (hs_cyc_q[3] - hs_cyc_q[2] !== 3) begin n_err++; $display("FAIL seq_rate_late: got %0d cycles want 3", hs_cyc_q[3] - hs_cyc_q[2]); end
  endtask

  task automatic test_grant_delay();
    do_reset(32'h8, 3, 0);
    mem_auto = 1'b1;
    ready    = 1'b1;
    for (int i = 0; i < 50 && hs_pc_q.size() < 4; i++) step();
    n_cmp++; if (hs_pc_q.size() < 4) begin n_err++; $display("FAIL gdly_timeout: got %0d handshakes want 4", hs_pc_q.size()); end
    n_cmp++; if (req8_cnt !== 4) begin n_err++; $display("FAIL gdly_req_cycles_at_8: got %0d want 4", req8_cnt); end
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (grant_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gdly_addr[%0d]: got %h want %h", i, grant_q[i], exp_q[i]); end
      n_cmp++; if (hs_pc_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gdly_instr_pc[%0d]: got %h want %h", i, hs_pc_q[i], exp_q[i]); end
    end
    n_cmp++; if (hs_cyc_q[2] - hs_cyc_q[1] !== 6) begin n_err++; $display("FAIL gdly_gap: got %0d cycles want 6", hs_cyc_q[2] - hs_cyc_q[1]); end
  endtask

  task automatic test_redirect_wait();
    do_reset(32'hFFFF_FFFF, 0, 0);
    mem_auto = 1'b1;
    ready    = 1'b1;
    for (int i = 0; i < 40 && !(dut_state == WAIT && u_bus.imem_addr_o == 32'h10); i++) step();
    n_cmp++; if (dut_state !== WAIT || u_bus.imem_addr_o !== 32'h10) begin n_err++; $display("FAIL rdw_reach_wait: got state=%0d addr=%h want WAIT at 00000010", dut_state, u_bus.imem_addr_o); end
    redirect      = 1'b1;
    redirect_addr = 32'h103;
    step();
    redirect = 1'b0;
    n_cmp++; if (u_bus.imem_req_o !== 1'b1 || u_bus.imem_addr_o !== 32'h100) begin n_err++; $display("FAIL rdw_next_req: got req=%b addr=%h want req=1 addr=00000100", u_bus.imem_req_o, u_bus.imem_addr_o); end
    for (int i = 0; i < 20 && hs_pc_q.size() < 5; i++) step();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100};
    n_cmp++; if (hs_pc_q.size() !== 5) begin n_err++; $display("FAIL rdw_hs_count: got %0d want 5", hs_pc_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (hs_pc_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rdw_instr_pc[%0d]: got %h want %h", i, hs_pc_q[i], exp_q[i]); end
    end
    n_cmp++; if (hs_instr_q[4] !== 32'h100) begin n_err++; $display("FAIL rdw_instr: got %h want 00000100", hs_instr_q[4]); end
  endtask

  task automatic test_redirect_kill();
    do_reset(32'hFFFF_FFFF, 0, 2);
    mem_auto = 1'b1;
    ready    = 1'b1;
    for (int i = 0; i < 40 && !(dut_state == WAIT && u_bus.imem_addr_o == 32'h8); i++) step();
    n_cmp++; if (dut_state !== WAIT || u_bus.imem_addr_o !== 32'h8) begin n_err++; $display("FAIL kill_reach_wait: got state=%0d addr=%h want WAIT at 00000008", dut_state, u_bus.imem_addr_o); end
    redirect      = 1'b1;
    redirect_addr = 32'h40;
    step();
    redirect = 1'b0;
    n_cmp++; if (dut_state !== WAIT || u_bus.imem_addr_o !== 32'h40) begin n_err++; $display("FAIL kill_still_wait: got state=%0d addr=%h want WAIT at 00000040", dut_state, u_bus.imem_addr_o); end
    for (int i = 0; i < 30 && hs_pc_q.size() < 3; i++) step();
    exp_q = '{32'h0, 32'h4, 32'h40};
    n_cmp++; if (hs_pc_q.size() < 3) begin n_err++; $display("FAIL kill_timeout: got %0d handshakes want 3", hs_pc_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (hs_pc_q[i] !== exp_q[i]) begin n_err++; $display("FAIL kill_instr_pc[%0d]: got %h want %h", i, hs_pc_q[i], exp_q[i]); end
    end
    n_cmp++; if (hs_instr_q[2] !== 32'h40) begin n_err++; $display("FAIL kill_instr: got %h want 00000040", hs_instr_q[2]); end
    n_cmp++; if (grant_q[3] !== 32'h40) begin n_err++; $display("FAIL kill_grant_after: got %h want 00000040", grant_q[3]); end
  endtask

  task automatic test_redirect_hold();
    do_reset(32'hFFFF_FFFF, 0, 0);
    mem_auto = 1'b1;
    ready    = 1'b0;
    for (int i = 0; i < 20 && dut_state != HOLD; i++) step();
    n_cmp++; if (u_bus.instr_valid_o !== 1'b1 || u_bus.instr_pc_o !== 32'h0) begin n_err++; $display("FAIL rdh_hold: got valid=%b pc=%h want valid=1 pc=00000000", u_bus.instr_valid_o, u_bus.instr_pc_o); end
    step();
    n_cmp++; if (u_bus.instr_valid_o !== 1'b1) begin n_err++; $display("FAIL rdh_hold_stays: got %b want 1", u_bus.instr_valid_o); end
    redirect      = 1'b1;
    redirect_addr = 32'h40;
    step();
    redirect = 1'b0;
    n_cmp++; if (u_bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rdh_valid_drop: got %b want 0", u_bus.instr_valid_o); end
    n_cmp++; if (u_bus.imem_req_o !== 1'b1 || u_bus.imem_addr_o !== 32'h40) begin n_err++; $display("FAIL rdh_next_req: got req=%b addr=%h want req=1 addr=00000040", u_bus.imem_req_o, u_bus.imem_addr_o); end
    ready = 1'b1;
    for (int i = 0; i < 20 && hs_pc_q.size() < 1; i++) step();
    n_cmp++; if (hs_pc_q[0] !== 32'h40 || hs_instr_q[0] !== 32'h40) begin n_err++; $display("FAIL rdh_first_hs: got pc=%h instr=%h want 00000040", hs_pc_q[0], hs_instr_q[0]); end
  endtask

  task automatic test_stall_hold();
    int req_cnt;
    do_reset(32'hFFFF_FFFF, 0, 0);
    mem_auto = 1'b1;
    ready    = 1'b0;
    for (int i = 0; i < 20 && dut_state != HOLD; i++) step();
    n_cmp++; if (dut_state !== HOLD) begin n_err++; $display("FAIL stall_reach_hold: got %0d want %0d", dut_state, HOLD); end
    stall = 1'b1;
    ready = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (u_bus.imem_req_o) req_cnt++;
    end
    n_cmp++; if (req_cnt !== 0) begin n_err++; $display("FAIL stall_no_req: got %0d request cycles want 0", req_cnt); end
    n_cmp++; if (dut_state !== IDLE) begin n_err++; $display("FAIL stall_idle: got %0d want %0d", dut_state, IDLE); end
    n_cmp++; if (hs_pc_q.size() !== 1) begin n_err++; $display("FAIL stall_hs_count: got %0d want 1", hs_pc_q.size()); end
    stall = 1'b0;
    step();
    n_cmp++; if (u_bus.imem_req_o !== 1'b1 || u_bus.imem_addr_o !== 32'h4) begin n_err++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=00000004", u_bus.imem_req_o, u_bus.imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset(32'hFFFF_FFFF, 0, 3);
    mem_auto = 1'b1;
    ready    = 1'b1;
    for (int i = 0; i < 30 && !(dut_state == WAIT && u_bus.imem_addr_o == 32'h4); i++) step();
    n_cmp++; if (dut_state !== WAIT) begin n_err++; $display("FAIL rmid_reach_wait: got %0d want %0d", dut_state, WAIT); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (dut_state !== IDLE || u_bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL rmid_state: got state=%0d req=%b want IDLE req=0", dut_state, u_bus.imem_req_o); end
    n_cmp++; if (u_bus.imem_addr_o !== 32'h0 || u_bus.instr_pc_o !== 32'h0 || u_bus.instr_o !== 32'h0) begin n_err++; $display("FAIL rmid_outputs: got addr=%h pc=%h instr=%h want zeros", u_bus.imem_addr_o, u_bus.instr_pc_o, u_bus.instr_o); end
    mem_auto = 1'b0;
    stall    = 1'b1;
    step();
    rst = 1'b0;
    step();
    m_rvalid = 1'b1;
    m_rdata  = 32'hDEAD_BEEF;
    step();
    m_rvalid = 1'b0;
    n_cmp++; if (dut_state !== IDLE || u_bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_late_rvalid: got state=%0d valid=%b want IDLE valid=0", dut_state, u_bus.instr_valid_o); end
    n_cmp++; if (u_bus.instr_o !== 32'h0) begin n_err++; $display("FAIL rmid_late_data: got %h want 00000000", u_bus.instr_o); end
    stall = 1'b0;
    step();
    n_cmp++; if (u_bus.imem_req_o !== 1'b1 || u_bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL rmid_restart: got req=%b addr=%h want req=1 addr=00000000", u_bus.imem_req_o, u_bus.imem_addr_o); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_wrap();
    test_sequential();
    test_grant_delay();
    test_redirect_wait();
    test_redirect_kill();
    test_redirect_hold();
    test_stall_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
